// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration (IDLE/SETUP/ACCESS).
// Optional ACCESS-phase timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 req0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic                 write0,
  input  logic [31:0]          wdata0,
  output logic                 done0,
  output logic [31:0]          rdata0,
  output logic                 err0,
  input  logic                 req1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic                 write1,
  input  logic [31:0]          wdata1,
  output logic                 done1,
  output logic [31:0]          rdata1,
  output logic                 err1,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic                   pick;
  logic                   timeout_hit;
  logic                   xfer_end;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of earlier stalled ACCESS cycles, so the abort lands on cycle TIMEOUT.
  assign timeout_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pick         = (req0 && req1) ? ~last_grant_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = pick;
          last_grant_d = pick;
          paddr_d      = pick ? addr1  : addr0;
          pwrite_d     = pick ? write1 : write0;
          pwdata_d     = pick ? wdata1 : wdata0;
          state_d      = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (PREADY || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign PSEL     = (state_q != IDLE);
  assign PENABLE  = (state_q == ACCESS);
  assign busy     = PSEL;
  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PWDATA   = pwdata_q;

  assign xfer_end = (state_q == ACCESS) && (PREADY || timeout_hit);
  assign done0    = xfer_end && !grant_q;
  assign done1    = xfer_end &&  grant_q;
  assign rdata0   = timeout_hit ? '0 : PRDATA;
  assign rdata1   = timeout_hit ? '0 : PRDATA;
  assign err0     = done0 && (PSLVERR || timeout_hit);
  assign err1     = done1 && (PSLVERR || timeout_hit);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter; exercises the timeout path when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;
  localparam int AW = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req0, req1, write0, write1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          done0, done1, err0, err1;
  logic [31:0]   rdata0, rdata1;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;

  apb_master_arbiter #(.ADDRWIDTH(AW), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .addr0(addr0), .write0(write0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .write1(write1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Monitor: every completion strobe must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    exp_t e;
    check("err_without_done", {err1 & ~done1, err0 & ~done0}, 2'b00);
    if (done0 || done1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done0=%b done1=%b with nothing outstanding (t=%0t)",
                 done0, done1, $time);
      end else begin
        e = exp_q.pop_front();
        check("done_port", {done1, done0}, (e.port == 1) ? 2'b10 : 2'b01);
        check("rdata", (e.port == 1) ? rdata1 : rdata0, e.rdata);
        check("err",   (e.port == 1) ? err1   : err0,   e.err);
      end
    end
  end

  task automatic xfer(input int p, input logic [AW-1:0] a, input logic w,
                      input logic [31:0] wd, input int waits,
                      input logic [31:0] rd, input logic se, input bit drop_early);
    exp_q.push_back('{port: p, rdata: rd, err: se});
    if (p == 0) begin
      req0 = 1'b1; addr0 = a; write0 = w; wdata0 = wd;
    end else begin
      req1 = 1'b1; addr1 = a; write1 = w; wdata1 = wd;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    tick();
    check("setup_psel",    PSEL,    1'b1);
    check("setup_penable", PENABLE, 1'b0);
    check("setup_paddr",   PADDR,   a);
    check("setup_pwrite",  PWRITE,  w);
    check("setup_pwdata",  PWDATA,  wd);
    if (drop_early) begin
      req0 = 1'b0; req1 = 1'b0;
    end
    for (int k = 0; k <= waits; k++) begin
      tick();
      check("access_penable", PENABLE, 1'b1);
      check("access_paddr",   PADDR,   a);
      check("access_pwdata",  PWDATA,  wd);
      if (k == waits) begin
        PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
      end
    end
    tick();
    check("idle_psel", PSEL, 1'b0);
    check("idle_busy", busy, 1'b0);
    req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit held;
    PRESET = 1'b1;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick();
    check("reset_psel",    PSEL,    1'b0);
    check("reset_penable", PENABLE, 1'b0);
    check("reset_paddr",   PADDR,   16'h0);
    check("reset_pwrite",  PWRITE,  1'b0);
    check("reset_pwdata",  PWDATA,  32'h0);
    check("reset_busy",    busy,    1'b0);
    PRESET = 1'b0;

    // Both requesters held from reset: 0,1,0,1 with 3 cycles per transfer.
    req0 = 1'b1; addr0 = 16'h0100; write0 = 1'b1; wdata0 = 32'h11;
    req1 = 1'b1; addr1 = 16'h0200; write1 = 1'b0; wdata1 = 32'h22;
    PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{port: i % 2, rdata: 32'h1234_5678, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_setup_paddr", PADDR, (i % 2 == 1) ? 16'h0200 : 16'h0100);
      check("rr_setup_penable", PENABLE, 1'b0);
      tick();
      check("rr_access_penable", PENABLE, 1'b1);
      tick();
      check("rr_idle_psel", PSEL, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0;

    // Single write on port 1 (last grant was 1), then write on port 0.
    xfer(1, 16'h0300, 1'b1, 32'h33, 0, 32'h0BAD_0001, 1'b0, 1'b0);
    xfer(0, 16'h1004, 1'b1, 32'hA5, 0, 32'h600D_0001, 1'b0, 1'b0);
    tick();
    check("no_regrant_psel", PSEL, 1'b0);
    // Port 0 again alone even though it was granted last.
    xfer(0, 16'h1008, 1'b0, 32'h0, 1, 32'h0000_C0DE, 1'b0, 1'b1);
    // Read on port 1 with four wait states and a slave error.
    xfer(1, 16'h2ABC, 1'b0, 32'h0, 4, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset during ACCESS aborts; contention afterwards goes to port 0.
    req0 = 1'b1; addr0 = 16'h3000; write0 = 1'b1; wdata0 = 32'h44; PREADY = 1'b0;
    tick();
    tick();
    check("pre_reset_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    tick();
    check("mid_reset_psel",  PSEL,  1'b0);
    check("mid_reset_busy",  busy,  1'b0);
    check("mid_reset_paddr", PADDR, 16'h0);
    PRESET = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr1 = 16'h4000;
    exp_q.push_back('{port: 0, rdata: 32'h55, err: 1'b0});
    tick();
    check("post_reset_paddr", PADDR, 16'h3000);
    PREADY = 1'b1; PRDATA = 32'h55;
    tick();
    tick();
    req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0;
    tick();

`ifdef APB_ARB_TIMEOUT_EN
    exp_q.push_back('{port: 0, rdata: 32'h0, err: 1'b1});
    req0 = 1'b1; addr0 = 16'h5000; PRDATA = 32'hCAFE_F00D; PREADY = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("timeout_done0", done0, (k == 8) ? 1'b1 : 1'b0);
    end
    tick();
    req0 = 1'b0;
    check("timeout_psel_after", PSEL, 1'b0);
`else
    exp_q.push_back('{port: 0, rdata: 32'h77, err: 1'b0});
    req0 = 1'b1; addr0 = 16'h5000; PREADY = 1'b0;
    tick();
    held = 1'b1;
    repeat (100) begin
      tick();
      if (!PSEL || !PENABLE) held = 1'b0;
    end
    check("no_timeout_held", held, 1'b1);
    PREADY = 1'b1; PRDATA = 32'h77;
    tick();
    req0 = 1'b0; PREADY = 1'b0;
    check("no_timeout_release_psel", PSEL, 1'b0);
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
